// File: rtl/i2c_responder.sv
// I2C target (responder): oversamples SCL/SDA, detects START/STOP, matches a
// 7-bit address and then receives write bytes or transmits read bytes.
// Optional feature macro: I2C_RESP_GCALL_EN (accept the general-call write address 8'h00).
module i2c_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       op,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       op_q, op_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  // Address match; general call is a write-only broadcast when enabled.
  function automatic logic addr_match(input logic [6:0] addr, input logic rw);
`ifdef I2C_RESP_GCALL_EN
    return (addr == SLAVE_ADDR) || ((addr == 7'h00) && !rw);
`else
    return (addr == SLAVE_ADDR) && !((addr == 7'h00) && rw && 1'b0);
`endif
  endfunction

  // Synchronizer shift: new raw sample enters at bit 0, oldest at the top.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_cond = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Synchronizer and previous-sample flops; idle bus is high on both lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Next-state and output logic; bus START/STOP override every state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    op_d        = op_q;
    busy_d      = busy_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    if (start_cond) begin
      state_d     = ADDR;
      bit_cnt_d   = 4'd0;
      busy_d      = 1'b0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_cond) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (addr_match(shift_q[6:0], sda_s)) begin
                op_d    = sda_s;
                busy_d  = 1'b1;
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          // sda_oe_q distinguishes the fall that opens the ACK slot from the one closing it.
          if (scl_rise && sda_oe_q && op_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (op_q) begin
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 4'd1;
              state_d   = RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            bit_cnt_d  = 4'd0;
            state_d    = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          // bit_cnt counts bits already placed on the bus.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end else if (scl_fall) begin
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 4'd1;
            state_d   = RD_DATA;
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers; the shift register needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      sda_oe_q    <= 1'b0;
      op_q        <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sda_oe_q    <= sda_oe_d;
      op_q        <= op_d;
      busy_q      <= busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Shift register for address, write and read data.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sda_oe    = sda_oe_q;
  assign op        = op_q;
  assign busy      = busy_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: bit-banged initiator on an open-drain SDA model.
module tb_i2c_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_i;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic       op;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       start_det;
  logic       stop_det;

  int total = 0;
  int bad   = 0;

  int         rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cycles = 0;
  logic [7:0] rx_log [0:15];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_bus), .sda_oe(sda_oe),
    .op(op), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .start_det(start_det), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  // Pulse and drive monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[3:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req)    tx_cnt    <= tx_cnt + 1;
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det)  stop_cnt  <= stop_cnt + 1;
    if (sda_oe)    oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period; returns the bus level sampled mid-high.
  task automatic bit_xfer(input logic b, output logic rd);
    clks(4); m_sda = b;
    clks(4); scl_i = 1'b1;
    clks(4); rd = sda_bus;
    clks(4); scl_i = 1'b0;
  endtask

  task automatic do_start();
    m_sda = 1'b1; scl_i = 1'b1; clks(6);
    m_sda = 1'b0; clks(6);
    scl_i = 1'b0;
  endtask

  task automatic do_rstart();
    clks(4); m_sda = 1'b1;
    clks(4); scl_i = 1'b1;
    clks(6); m_sda = 1'b0;
    clks(6); scl_i = 1'b0;
  endtask

  task automatic do_stop();
    clks(4); m_sda = 1'b0;
    clks(4); scl_i = 1'b1;
    clks(6); m_sda = 1'b1;
    clks(8);
  endtask

  // Sends a byte; ack_low=1 when the bus was low in the ACK slot.
  task automatic write_byte(input logic [7:0] d, output logic ack_low);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    ack_low = ~r;
  endtask

  // Reads a byte, updates tx_data before the ACK slot, then ACKs (0) or NACKs (1).
  task automatic read_byte(input logic [7:0] next_tx, input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    tx_data = next_tx;
    bit_xfer(ack_bit, r);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         s0, p0, r0, t0, o0;

    rst = 1'b1; scl_i = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    clks(6);
    check("rst_sda_oe", {31'd0, sda_oe}, 0);
    check("rst_op", {31'd0, op}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rx_data", {24'd0, rx_data}, 0);
    check("rst_pulses", {28'd0, rx_valid, tx_req, start_det, stop_det}, 0);
    rst = 1'b0;
    clks(6);

    // Write 0xA5, 0x3C to 0x22.
    do_start();
    write_byte(8'h44, a); check("t1_addr_ack", {31'd0, a}, 1);
    check("t1_busy", {31'd0, busy}, 1);
    check("t1_op", {31'd0, op}, 0);
    write_byte(8'hA5, a); check("t1_d1_ack", {31'd0, a}, 1);
    write_byte(8'h3C, a); check("t1_d2_ack", {31'd0, a}, 1);
    do_stop();
    check("t1_rx_cnt", rx_cnt, 2);
    check("t1_rx0", {24'd0, rx_log[0]}, 32'hA5);
    check("t1_rx1", {24'd0, rx_log[1]}, 32'h3C);
    check("t1_start_cnt", start_cnt, 1);
    check("t1_stop_cnt", stop_cnt, 1);
    check("t1_busy_after", {31'd0, busy}, 0);

    // Read 0x96 (ACK) then 0x0F (NACK).
    tx_data = 8'h96; t0 = tx_cnt;
    do_start();
    write_byte(8'h45, a); check("t2_addr_ack", {31'd0, a}, 1);
    check("t2_op", {31'd0, op}, 1);
    read_byte(8'h0F, 1'b0, d); check("t2_byte1", {24'd0, d}, 32'h96);
    read_byte(8'h55, 1'b1, d); check("t2_byte2", {24'd0, d}, 32'h0F);
    clks(4);
    check("t2_tx_req_cnt", tx_cnt - t0, 2);
    check("t2_busy_nack", {31'd0, busy}, 0);
    do_stop();

    // Foreign address 0x23.
    r0 = rx_cnt; o0 = oe_cycles;
    do_start();
    write_byte(8'h46, a); check("t3_no_ack", {31'd0, a}, 0);
    check("t3_busy", {31'd0, busy}, 0);
    write_byte(8'h12, a);
    do_stop();
    check("t3_oe_cycles", oe_cycles - o0, 0);
    check("t3_rx_cnt", rx_cnt - r0, 0);

    // Write then repeated START into a read.
    s0 = start_cnt; r0 = rx_cnt; tx_data = 8'hC3;
    do_start();
    write_byte(8'h44, a); check("t4_wr_ack", {31'd0, a}, 1);
    check("t4_op_wr", {31'd0, op}, 0);
    write_byte(8'hA5, a); check("t4_d_ack", {31'd0, a}, 1);
    do_rstart();
    write_byte(8'h45, a); check("t4_rd_ack", {31'd0, a}, 1);
    check("t4_op_rd", {31'd0, op}, 1);
    read_byte(8'h00, 1'b1, d); check("t4_rd_byte", {24'd0, d}, 32'hC3);
    do_stop();
    check("t4_start_cnt", start_cnt - s0, 2);
    check("t4_rx_cnt", rx_cnt - r0, 1);
    check("t4_rx_val", {24'd0, rx_log[r0[3:0]]}, 32'hA5);

    // STOP after four data bits, then a normal transfer.
    r0 = rx_cnt; p0 = stop_cnt;
    do_start();
    write_byte(8'h44, a); check("t5_addr_ack", {31'd0, a}, 1);
    bit_xfer(1'b1, a); bit_xfer(1'b0, a); bit_xfer(1'b1, a); bit_xfer(1'b1, a);
    do_stop();
    check("t5_stop_cnt", stop_cnt - p0, 1);
    check("t5_no_rx", rx_cnt - r0, 0);
    check("t5_busy", {31'd0, busy}, 0);
    do_start();
    write_byte(8'h44, a); check("t5_re_ack", {31'd0, a}, 1);
    write_byte(8'h11, a); check("t5_re_d_ack", {31'd0, a}, 1);
    do_stop();
    check("t5_rx_cnt", rx_cnt - r0, 1);
    check("t5_rx_val", {24'd0, rx_log[r0[3:0]]}, 32'h11);

    // Reset while the responder holds SDA in the address ACK slot.
    do_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h44;
      bit_xfer(d[i], a);
    end
    clks(6);
    check("t6_oe_before", {31'd0, sda_oe}, 1);
    rst = 1'b1;
    clks(1);
    check("t6_oe_after", {31'd0, sda_oe}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_op", {31'd0, op}, 0);
    check("t6_rx_data", {24'd0, rx_data}, 0);
    check("t6_pulses", {28'd0, rx_valid, tx_req, start_det, stop_det}, 0);
    m_sda = 1'b1; clks(2); scl_i = 1'b1; clks(2);
    rst = 1'b0;
    clks(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
